// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that funnels NUM_REQ requesters into
// one FIFO write port in the write-clock domain.
// Optional feature macro: WR_ARB_PKT_LOCK_EN. When it is defined, a grant is
// held for a whole packet and released only by a beat with req_last set.
// Without it, every accepted beat releases the grant.
//
// Handshake: a beat moves when req_valid[g] & req_ready[g] is seen at a rising
// wrt_clk edge. Only the current owner g can see req_ready high, and only while
// full is low. The ready signal does not depend on the owner's own valid.
// wrt_en marks exactly those transfer cycles.
//
// Debug visibility: busy is the FSM state (GRANT = 1). grant is the registered
// one-hot owner.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      wrt_clk,
  input  logic                      wrt_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  output logic                      wrt_en,
  output logic [DATA_W-1:0]         wrt_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_owner_q;

  logic [IDX_W-1:0]   winner_d;
  logic               any_valid;
  logic               owner_valid;
  logic               xfer;
  logic               end_own;
  logic               drop_own;

  // Round-robin winner: the first valid requester after last_owner, with wrap.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner_d = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_owner_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[IDX_W-1:0]]) begin
        found    = 1'b1;
        winner_d = idx[IDX_W-1:0];
      end
    end
  end

  assign any_valid   = |req_valid;
  assign owner_valid = req_valid[owner_q];
  assign xfer        = (state_q == GRANT) && owner_valid && !full;

`ifdef WR_ARB_PKT_LOCK_EN
  // The grant ends only on the last beat. A stall of the owner keeps the grant.
  assign end_own  = xfer && req_last[owner_q];
  assign drop_own = 1'b0;
`else
  // Every beat ends the grant. If the owner lets go of valid, the grant returns
  // to IDLE without updating last_owner.
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign end_own  = xfer;
  assign drop_own = (state_q == GRANT) && !owner_valid && !full;
`endif

  // Arbitration FSM. grant and the owner index are registered.
  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            state_q <= GRANT;
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_d;
            owner_q <= winner_d;
          end else begin
            grant_q <= '0;
          end
        end
        GRANT: begin
          if (end_own) begin
            last_owner_q <= owner_q;
            grant_q      <= '0;
            state_q      <= IDLE;
          end else if (drop_own) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_q == GRANT);
  assign grant     = grant_q;
  assign req_ready = (busy && !full) ? grant_q : '0;
  assign wrt_en    = xfer;
  assign wrt_data  = busy ? req_data[owner_q*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8). Inputs change on
// the falling edge. Outputs are sampled 1 ns later, and the DUT reacts on the
// rising edge.
// The packet-lock checks are built when WR_ARB_PKT_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             full;
  logic             wrt_en;
  logic [DW-1:0]    wrt_data;
  logic [NR-1:0]    grant;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  // Observed bundle: {busy, grant, wrt_en, req_ready, wrt_data}
  logic [17:0] obs;
  logic [17:0] ex;
  assign obs = {busy, grant, wrt_en, req_ready, wrt_data};

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .wrt_clk   (clk),
    .wrt_rst_n (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wrt_en    (wrt_en),
    .wrt_data  (wrt_data),
    .grant     (grant),
    .busy      (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] exp_of(input logic b, input logic [3:0] g,
                                         input logic e, input logic [3:0] r,
                                         input logic [7:0] d);
    return {b, g, e, r, d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_last = '0; full = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk); req_valid = 4'b1111; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL reset_state: got %h expected %h", obs, ex); end
    @(negedge clk); rst_n = 1'b1; req_valid = '0;
  endtask

  // Hold all four requesters valid; the grant order must be 0,1,2,3,0 with a bubble between grants.
  task automatic test_round_robin();
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] dat   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    @(negedge clk); req_valid = 4'b1111; req_last = 4'b1111; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL rr_idle_start: got %h expected %h", obs, ex); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      ex = exp_of(1'b1, order[k], 1'b1, order[k], dat[k]); n_checks++;
      if (obs !== ex) begin n_errors++; $display("FAIL rr_grant%0d: got %h expected %h", k, obs, ex); end
      @(negedge clk);
      if (k == 4) req_valid = '0;
      #1;
      ex = '0; n_checks++;
      if (obs !== ex) begin n_errors++; $display("FAIL rr_bubble%0d: got %h expected %h", k, obs, ex); end
    end
  endtask

  // Hold full high for 5 cycles; the pending beat must go out on the first cycle after full falls.
  task automatic test_full_stall();
    @(negedge clk); req_valid = 4'b0100; req_last = 4'b0100; #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); full = 1'b1; #1;
      ex = exp_of(1'b1, 4'b0100, 1'b0, 4'b0000, 8'h33); n_checks++;
      if (obs !== ex) begin n_errors++; $display("FAIL full_hold%0d: got %h expected %h", c, obs, ex); end
    end
    @(negedge clk); full = 1'b0; #1;
    ex = exp_of(1'b1, 4'b0100, 1'b1, 4'b0100, 8'h33); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL full_release_write: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = '0; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL full_after_idle: got %h expected %h", obs, ex); end
  endtask

`ifndef WR_ARB_PKT_LOCK_EN
  // Here last_owner = 2. If the owner drops valid, the grant returns to IDLE and last_owner stays 2.
  task automatic test_valid_drop();
    @(negedge clk); req_valid = 4'b0010; req_last = '0; #1;
    @(negedge clk); req_valid = 4'b0000; #1;
    ex = exp_of(1'b1, 4'b0010, 1'b0, 4'b0010, 8'h22); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL drop_no_write: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = 4'b0110; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL drop_back_idle: got %h expected %h", obs, ex); end
    // Search starts at 3, so 1 wins. If last_owner had moved to 1, 2 would win.
    @(negedge clk); #1;
    ex = exp_of(1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL drop_next_winner: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = '0; #1;
  endtask
`else
  // Make 1 the last owner. Then requester 2 sends a 3-beat packet with a stall in the middle
  // while requester 1 is also valid.
  task automatic test_packet_lock();
    @(negedge clk); req_valid = 4'b0010; req_last = 4'b0010; #1;
    @(negedge clk); #1;
    ex = exp_of(1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_setup: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = 4'b0110; req_last = 4'b0000; req_data[16 +: 8] = 8'hA1; #1;
    @(negedge clk); #1;
    ex = exp_of(1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA1); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_beat1: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = 4'b0010; #1;
    ex = exp_of(1'b1, 4'b0100, 1'b0, 4'b0100, 8'hA1); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_stall_hold: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = 4'b0110; req_data[16 +: 8] = 8'hA2; #1;
    ex = exp_of(1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA2); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_beat2: got %h expected %h", obs, ex); end
    @(negedge clk); req_data[16 +: 8] = 8'hA3; req_last = 4'b0100; #1;
    ex = exp_of(1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA3); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_beat3: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = 4'b0010; req_last = 4'b0010; req_data[16 +: 8] = 8'h33; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_bubble: got %h expected %h", obs, ex); end
    @(negedge clk); #1;
    ex = exp_of(1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL lock_next_owner: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = '0; #1;
  endtask
`endif

  // A lone requester must be re-granted after every bubble.
  task automatic test_back_to_back();
    @(negedge clk); req_valid = 4'b1000; req_last = 4'b1000; #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      ex = exp_of(1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44); n_checks++;
      if (obs !== ex) begin n_errors++; $display("FAIL single_grant%0d: got %h expected %h", k, obs, ex); end
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      ex = '0; n_checks++;
      if (obs !== ex) begin n_errors++; $display("FAIL single_bubble%0d: got %h expected %h", k, obs, ex); end
    end
  endtask

  // Assert reset asynchronously during beat 2 of a packet from requester 2. Afterwards 0 must beat 3.
  task automatic test_reset_mid_packet();
    bit seen;
    @(negedge clk); req_valid = 4'b0100; req_last = 4'b0000; #1;
    @(negedge clk); #1;
    ex = exp_of(1'b1, 4'b0100, 1'b1, 4'b0100, 8'h33); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL rst_beat1: got %h expected %h", obs, ex); end
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk); #1;
      if (busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL rst_beat2_wait: got busy=%b expected 1 within 4 cycles", busy); end
    #2; rst_n = 1'b0; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL rst_async_clear: got %h expected %h", obs, ex); end
    @(negedge clk); rst_n = 1'b1; req_valid = 4'b1001; req_last = 4'b1001; #1;
    ex = '0; n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL rst_release_idle: got %h expected %h", obs, ex); end
    @(negedge clk); #1;
    ex = exp_of(1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11); n_checks++;
    if (obs !== ex) begin n_errors++; $display("FAIL rst_winner0: got %h expected %h", obs, ex); end
    @(negedge clk); req_valid = '0; #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_stall();
`ifndef WR_ARB_PKT_LOCK_EN
    test_valid_drop();
`else
    test_packet_lock();
`endif
    test_back_to_back();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
